// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit -- iterative multiply/divide unit for the EX stage.
//
// Handles mult/multu/div/divu with a 32-step radix-2 datapath (shift-add for
// multiply, restoring shift-subtract for divide). Also handles the HI/LO
// transfers mthi/mtlo/mfhi/mflo.
//
// Ports:
//   Clk            clock, all state updates on posedge
//   Reset          asynchronous active-low reset
//   EX_Valid       a real instruction occupies EX
//   EX_RType       EX instruction is R-type
//   EX_func        function field of the EX instruction
//   EX_ReadData1   rs operand (dividend / multiplier / mthi-mtlo data)
//   EX_ReadData2   rt operand (divisor / multiplicand)
//   MulDiv_Busy    stall request to the hazard unit
//   MulDiv_Result  mfhi/mflo read data (0 for other instructions)
//   HI, LO         architectural HI/LO registers
module ex_muldiv_unit (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        EX_Valid,
  input  logic        EX_RType,
  input  logic [5:0]  EX_func,
  input  logic [31:0] EX_ReadData1,
  input  logic [31:0] EX_ReadData2,
  output logic        MulDiv_Busy,
  output logic [31:0] MulDiv_Result,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, state_nx;
  logic [5:0]  cnt;
  logic [31:0] opb;     // |multiplicand| or |divisor|
  logic [31:0] acc;     // product high half / partial remainder
  logic [31:0] shreg;   // multiplier -> product low half / dividend -> quotient
  logic        op_div, neg_q, neg_r, div0;

  // Decode is also gated by Reset so outputs are quiet while reset is held.
  logic dec, is_mul, is_div, start, last_step;
  logic sgn, a_neg, b_neg;

  assign dec       = EX_Valid & EX_RType & Reset;
  assign is_mul    = dec & ((EX_func == F_MULT) | (EX_func == F_MULTU));
  assign is_div    = dec & ((EX_func == F_DIV)  | (EX_func == F_DIVU));
  assign start     = (state == IDLE) & (is_mul | is_div);
  assign last_step = (state == RUN) & (cnt == 6'd31);

  assign MulDiv_Busy = start | (state == RUN);

  // Signed variants (mult, div) have funct bit 0 clear.
  assign sgn   = ~EX_func[0];
  assign a_neg = sgn & EX_ReadData1[31];
  assign b_neg = sgn & EX_ReadData2[31];

  always_comb begin
    MulDiv_Result = '0;
    if (dec && EX_func == F_MFHI) MulDiv_Result = HI;
    if (dec && EX_func == F_MFLO) MulDiv_Result = LO;
  end

  // One radix-2 step, plus the sign-corrected result used on the final step.
  logic [32:0] mul_sum, r_sh;
  logic [31:0] sub, acc_nx, sh_nx, q_fix, r_fix, hi_res, lo_res;
  logic [63:0] prod, prod_fix;
  logic        ge;

  always_comb begin
    mul_sum = {1'b0, acc} + (shreg[0] ? {1'b0, opb} : 33'd0);
    r_sh    = {acc, shreg[31]};
    ge      = r_sh >= {1'b0, opb};
    sub     = 32'(r_sh - {1'b0, opb});
    if (op_div) begin
      acc_nx = ge ? sub : r_sh[31:0];
      sh_nx  = {shreg[30:0], ge};
    end else begin
      acc_nx = mul_sum[32:1];
      sh_nx  = {mul_sum[0], shreg[31:1]};
    end
    prod     = {acc_nx, sh_nx};
    prod_fix = neg_q ? -prod : prod;
    // Divide by zero naturally yields remainder |dividend|; the remainder sign
    // fix then restores the original dividend, so only the quotient is forced.
    q_fix    = div0 ? '1 : (neg_q ? -sh_nx : sh_nx);
    r_fix    = neg_r ? -acc_nx : acc_nx;
    hi_res   = op_div ? r_fix : prod_fix[63:32];
    lo_res   = op_div ? q_fix : prod_fix[31:0];
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (cnt == 6'd31) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cnt    <= '0;
      opb    <= '0;
      acc    <= '0;
      shreg  <= '0;
      op_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
      HI     <= '0;
      LO     <= '0;
    end else begin
      if (start) begin
        cnt    <= '0;
        acc    <= '0;
        shreg  <= a_neg ? -EX_ReadData1 : EX_ReadData1;
        opb    <= b_neg ? -EX_ReadData2 : EX_ReadData2;
        op_div <= is_div;
        neg_q  <= a_neg ^ b_neg;
        neg_r  <= a_neg;
        div0   <= (EX_ReadData2 == '0);
      end else if (state == RUN) begin
        cnt   <= cnt + 6'd1;
        acc   <= acc_nx;
        shreg <= sh_nx;
      end
      if (last_step) begin
        HI <= hi_res;
        LO <= lo_res;
      end else if (state == IDLE && dec) begin
        if (EX_func == F_MTHI) HI <= EX_ReadData1;
        if (EX_func == F_MTLO) LO <= EX_ReadData1;
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
module tb_ex_muldiv_unit;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        EX_Valid, EX_RType;
  logic [5:0]  EX_func;
  logic [31:0] EX_ReadData1, EX_ReadData2;
  logic        MulDiv_Busy;
  logic [31:0] MulDiv_Result, HI, LO;

  ex_muldiv_unit dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .EX_Valid      (EX_Valid),
    .EX_RType      (EX_RType),
    .EX_func       (EX_func),
    .EX_ReadData1  (EX_ReadData1),
    .EX_ReadData2  (EX_ReadData2),
    .MulDiv_Busy   (MulDiv_Busy),
    .MulDiv_Result (MulDiv_Result),
    .HI            (HI),
    .LO            (LO)
  );

  always #5 Clk = ~Clk;

  int unsigned vectors = 0;
  int unsigned errs    = 0;
  logic [31:0] m_hi, m_lo;   // architectural HI/LO as the model sees them

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_result();
    if (Reset && EX_Valid && EX_RType && EX_func == 6'h10) return m_hi;
    if (Reset && EX_Valid && EX_RType && EX_func == 6'h12) return m_lo;
    return 32'h0;
  endfunction

  task automatic chk_cycle(string tag, logic exp_busy);
    chk({tag, ".busy"},   {31'b0, MulDiv_Busy}, {31'b0, exp_busy});
    chk({tag, ".hi"},     HI, m_hi);
    chk({tag, ".lo"},     LO, m_lo);
    chk({tag, ".result"}, MulDiv_Result, exp_result());
  endtask

  function automatic bit is_md(bit v, bit r, logic [5:0] f);
    return v && r && (f == 6'h18 || f == 6'h19 || f == 6'h1A || f == 6'h1B);
  endfunction

  // Architectural results from plain arithmetic.
  task automatic model_md(logic [5:0] f, logic [31:0] a, logic [31:0] b,
                          output logic [31:0] hi, output logic [31:0] lo);
    logic signed [63:0] sp;
    logic [63:0] up;
    case (f)
      6'h18: begin
        sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        hi = sp[63:32]; lo = sp[31:0];
      end
      6'h19: begin
        up = {32'b0, a} * {32'b0, b};
        hi = up[63:32]; lo = up[31:0];
      end
      6'h1A: begin
        if (b == 0) begin lo = 32'hFFFFFFFF; hi = a; end
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin lo = 32'h80000000; hi = 0; end
        else begin lo = $signed(a) / $signed(b); hi = $signed(a) % $signed(b); end
      end
      default: begin
        if (b == 0) begin lo = 32'hFFFFFFFF; hi = a; end
        else begin lo = a / b; hi = a % b; end
      end
    endcase
  endtask

  // Called at posedge+1; returns at posedge+1 after the instruction leaves EX.
  task automatic issue(string tag, bit v, bit r, logic [5:0] f,
                       logic [31:0] a, logic [31:0] b);
    logic [31:0] eh, el;
    EX_Valid = v; EX_RType = r; EX_func = f; EX_ReadData1 = a; EX_ReadData2 = b;
    if (is_md(v, r, f)) begin
      model_md(f, a, b, eh, el);
      @(negedge Clk); chk_cycle(tag, 1'b1);
      for (int i = 1; i <= 32; i++) begin
        @(posedge Clk); #1;
        EX_Valid = 1'($urandom); EX_RType = 1'($urandom); EX_func = 6'($urandom);
        EX_ReadData1 = $urandom; EX_ReadData2 = $urandom;
        @(negedge Clk); chk_cycle(tag, 1'b1);
      end
      @(posedge Clk); #1;
      // DONE: finishing instruction still in EX, results now visible
      EX_Valid = v; EX_RType = r; EX_func = f; EX_ReadData1 = a; EX_ReadData2 = b;
      m_hi = eh; m_lo = el;
      @(negedge Clk); chk_cycle(tag, 1'b0);
      @(posedge Clk); #1;
    end else begin
      @(negedge Clk); chk_cycle(tag, 1'b0);
      @(posedge Clk); #1;
      if (v && r && f == 6'h11) m_hi = a;
      if (v && r && f == 6'h13) m_lo = a;
    end
  endtask

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'($urandom_range(0, 20));
      4: return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [5:0] rnd_func();
    logic [5:0] tbl [10] = '{6'h18, 6'h19, 6'h1A, 6'h1B, 6'h10, 6'h11, 6'h12, 6'h13, 6'h20, 6'h00};
    return tbl[$urandom_range(0, 9)];
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b0; EX_Valid = 0; EX_RType = 0; EX_func = '0;
    EX_ReadData1 = '0; EX_ReadData2 = '0;
    m_hi = 0; m_lo = 0;
    repeat (2) @(posedge Clk); #1;
    chk_cycle("reset", 1'b0);
    @(negedge Clk); Reset = 1'b1;
    @(posedge Clk); #1;

    issue("mult", 1, 1, 6'h18, 32'hFFFFFFFE, 32'h3);
    chk("mult.hi_lit", HI, 32'hFFFFFFFF); chk("mult.lo_lit", LO, 32'hFFFFFFFA);
    issue("multu", 1, 1, 6'h19, 32'hFFFFFFFE, 32'h3);
    chk("multu.hi_lit", HI, 32'h2); chk("multu.lo_lit", LO, 32'hFFFFFFFA);
    issue("div", 1, 1, 6'h1A, -32'sd7, 32'd2);
    chk("div.lo_lit", LO, 32'hFFFFFFFD); chk("div.hi_lit", HI, 32'hFFFFFFFF);
    issue("divu", 1, 1, 6'h1B, 32'd100, 32'd7);
    chk("divu.lo_lit", LO, 32'd14); chk("divu.hi_lit", HI, 32'd2);
    issue("divu0", 1, 1, 6'h1B, 32'h1234, 32'h0);
    chk("divu0.lo_lit", LO, 32'hFFFFFFFF); chk("divu0.hi_lit", HI, 32'h1234);
    issue("divovf", 1, 1, 6'h1A, 32'h80000000, 32'hFFFFFFFF);
    chk("divovf.lo_lit", LO, 32'h80000000); chk("divovf.hi_lit", HI, 32'h0);

    issue("mthi", 1, 1, 6'h11, 32'hA5A5A5A5, 32'h0);
    issue("mflo", 1, 1, 6'h12, 32'h0, 32'h0);
    issue("mfhi", 1, 1, 6'h10, 32'h0, 32'h0);
    EX_Valid = 1; EX_RType = 1; EX_func = 6'h10; #1;
    chk("mfhi.lit", MulDiv_Result, 32'hA5A5A5A5);
    EX_func = 6'h12; #1;
    chk("mflo.lit", MulDiv_Result, 32'h80000000);
    chk("mf.busy_lit", {31'b0, MulDiv_Busy}, 32'h0);
    @(posedge Clk); #1;

    // mult held through DONE, then div immediately behind it
    issue("b2b_mult", 1, 1, 6'h18, 32'd1000, -32'sd3);
    issue("b2b_div", 1, 1, 6'h1A, 32'd1000, -32'sd3);
    chk("b2b.lo_lit", LO, -32'sd333); chk("b2b.hi_lit", HI, 32'd1);

    // asynchronous reset in the middle of RUN (counter at 10)
    EX_Valid = 1; EX_RType = 1; EX_func = 6'h18; EX_ReadData1 = 32'd7; EX_ReadData2 = 32'd9;
    repeat (11) @(posedge Clk);
    #3; EX_func = 6'h10; Reset = 1'b0; #1;
    m_hi = 0; m_lo = 0;
    chk("rst.busy", {31'b0, MulDiv_Busy}, 32'h0);
    chk("rst.hi", HI, 32'h0); chk("rst.lo", LO, 32'h0);
    chk("rst.result", MulDiv_Result, 32'h0);
    EX_Valid = 0;
    @(negedge Clk); Reset = 1'b1;
    @(posedge Clk); #1;
    issue("post_rst", 1, 1, 6'h18, 32'h12345, -32'sd77);

    for (int n = 0; n < 40; n++) begin
      logic [5:0] f;
      f = rnd_func();
      issue("rand", ($urandom_range(0, 9) != 0), ($urandom_range(0, 9) != 0), f, rnd_op(), rnd_op());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
EX_MULDIV_UNIT -- requirements
Module: ex_muldiv_unit

Interface
REQ-001 SHALL have ports: Clk  in  1  clock; all state updates on posedge.
REQ-002 SHALL have ports: Reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: EX_Valid  in  1  a real (non-bubble) instruction occupies EX.
REQ-004 SHALL have ports: EX_RType  in  1  the EX instruction is R-type (opcode 0).
REQ-005 SHALL have ports: EX_func  in  6  function field latched by ID/EX.
REQ-006 SHALL have ports: EX_ReadData1 / EX_ReadData2  in  32 each  rs / rt operands after forwarding.
REQ-007 SHALL have ports: MulDiv_Busy  out  1  stall request to hazard unit (freeze PC, IF/ID, ID/EX).
REQ-008 SHALL have ports: MulDiv_Result  out  32  mfhi/mflo read data to EX result mux.
REQ-009 SHALL have ports: HI, LO  out  32 each  architectural HI/LO registers.

Function
REQ-010 SHALL decode only when EX_Valid=1 and EX_RType=1: mult 0x18, multu 0x19, div 0x1A, divu 0x1B, mfhi 0x10, mthi 0x11, mflo 0x12, mtlo 0x13; all other funct values have no effect.
REQ-011 SHALL implement FSM states IDLE, RUN, DONE; Reset forces IDLE.
REQ-012 SHALL treat start as: IDLE and decoded mult/multu/div/divu.
REQ-013 SHALL drive MulDiv_Busy = start (combinational) OR state==RUN; in IDLE without start and in DONE it SHALL be 0.
REQ-014 SHALL on start: latch operands, take absolute values and result-sign flags for signed ops, clear 6-bit counter, go to RUN.
REQ-015 SHALL in RUN perform one radix-2 step per cycle (shift-add for multiply, restoring shift-subtract for divide), increment counter, and leave RUN after step 31 (32 RUN cycles).
REQ-016 SHALL on the RUN->DONE edge write HI/LO: multiply -> HI=product[63:32], LO=product[31:0] (signed product two's-complement); divide -> LO=quotient, HI=remainder.
REQ-017 SHALL truncate signed quotient toward zero, with remainder sign equal to the dividend sign.
REQ-018 SHALL on divisor 0 (either signedness) write LO=0xFFFFFFFF, HI=dividend, with identical 33-cycle timing.
REQ-019 SHALL on signed 0x80000000 / 0xFFFFFFFF write LO=0x80000000, HI=0.
REQ-020 SHALL hold DONE for exactly one cycle, ignore decode in DONE (the finishing instruction is still in EX), then return to IDLE.
REQ-021 SHALL give a total stall of 33 cycles from start cycle through last RUN cycle; results are visible on HI/LO from the DONE cycle onward.
REQ-022 SHALL in IDLE write HI=EX_ReadData1 on mthi and LO=EX_ReadData1 on mtlo at posedge; neither asserts Busy.
REQ-023 SHALL drive MulDiv_Result combinationally: HI on mfhi, LO on mflo, 0 otherwise; the value is the current register contents.
REQ-024 SHALL ignore changes on EX_Valid, EX_func and operands while in RUN or DONE; an operation once started always completes.
REQ-025 SHALL not modify HI/LO except per REQ-016, REQ-018, REQ-019, REQ-022 and reset.

Reset
REQ-026 SHALL on Reset=0, at any time including mid-RUN, immediately force state=IDLE, counter=0, HI=0, LO=0, internal operand/accumulator registers=0, MulDiv_Busy=0, MulDiv_Result=0 (no decode), without waiting for Clk.
REQ-027 SHALL after Reset release begin accepting operations at the first posedge.

Verification
REQ-028 SHALL check mult 0xFFFFFFFE x 0x00000003 -> Busy high 33 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; multu with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
REQ-029 SHALL check div -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu 100 / 7 -> LO=14, HI=2.
REQ-030 SHALL check divu 0x1234 / 0 -> LO=0xFFFFFFFF, HI=0x1234; div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-031 SHALL check mthi 0xA5A5A5A5 then mflo/mfhi -> no Busy; MulDiv_Result=0xA5A5A5A5 on mfhi, old LO on mflo.
REQ-032 SHALL check Reset=0 pulse in RUN counter=10 -> Busy drops asynchronously, HI=LO=0; a new mult after release completes correctly.
REQ-033 SHALL check mult held in EX through DONE with EX_Valid=1 -> no second start; the back-to-back div in the following cycle starts from IDLE.
